xc_malu_ctrl: RTL and testbench

- Sequencing and state-holding stage for the multi-precision ALU. It sits directly upstream of the combinational long-arithmetic datapath (xc.madd.3 / xc.msub.3 / xc.macc / xc.mmul.3).
- Generates the one-hot fsm_* step strobes and owns the acc/carry/count registers that the datapath reads.
- Captures the datapath's next-state values (n_acc, n_carry) each step and signals instruction completion to the issuing pipeline stage.

---
 rtl/xc_malu_pkg.sv | 31 +++
 rtl/xc_malu_ctrl.sv | 99 +++++++++
 tb/tb_xc_malu_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/xc_malu_pkg.sv
// Shared encodings for the multi-precision ALU control stage: state codes,
// default iteration count and micro-op bit positions.
package xc_malu_pkg;

  localparam int MDR_STEPS_DEF = 32;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_MDR    = 3'd1;
  localparam logic [2:0] ST_MSUB_1 = 3'd2;
  localparam logic [2:0] ST_MACC_1 = 3'd3;
  localparam logic [2:0] ST_MMUL_1 = 3'd4;
  localparam logic [2:0] ST_MMUL_2 = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  typedef enum logic [2:0] {
    S_INIT   = ST_INIT,
    S_MDR    = ST_MDR,
    S_MSUB_1 = ST_MSUB_1,
    S_MACC_1 = ST_MACC_1,
    S_MMUL_1 = ST_MMUL_1,
    S_MMUL_2 = ST_MMUL_2,
    S_DONE   = ST_DONE
  } state_t;

  localparam int UOP_MADD = 0;
  localparam int UOP_MSUB = 1;
  localparam int UOP_MACC = 2;
  localparam int UOP_MMUL = 3;
  localparam int UOP_N    = 4;

endpackage

// File: rtl/xc_malu_ctrl.sv
// Sequencer for the long-arithmetic datapath: one-hot step strobes, the
// acc/carry/count state the datapath reads, and completion handshake.
module xc_malu_ctrl
  import xc_malu_pkg::*;
#(
  parameter int MDR_STEPS = MDR_STEPS_DEF,
  parameter int COUNT_W   = 6
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               flush,
  input  logic               valid,
  input  logic               uop_madd,
  input  logic               uop_msub,
  input  logic               uop_macc,
  input  logic               uop_mmul,
  input  logic [63:0]        n_acc,
  input  logic               n_carry,
  output logic               fsm_init,
  output logic               fsm_mdr,
  output logic               fsm_msub_1,
  output logic               fsm_macc_1,
  output logic               fsm_mmul_1,
  output logic               fsm_mmul_2,
  output logic               fsm_done,
  output logic [63:0]        acc,
  output logic               carry,
  output logic [COUNT_W-1:0] count,
  output logic               ready
);

  state_t             state;
  state_t             state_nxt;
  logic [UOP_N-1:0]   uop;
  logic               uop_legal;
  logic               active;
  logic               last_mdr;

  assign uop       = {uop_mmul, uop_macc, uop_msub, uop_madd};
  assign uop_legal = $onehot(uop);
  assign active    = valid & ~flush;
  assign last_mdr  = (count == COUNT_W'(MDR_STEPS - 1));

  // Any inactive cycle (flush or valid low) collapses straight back to INIT.
  always_comb begin
    state_nxt = S_INIT;
    if (active) begin
      case (state)
        S_INIT: begin
          if (uop_legal) begin
            if (uop[UOP_MSUB])      state_nxt = S_MSUB_1;
            else if (uop[UOP_MACC]) state_nxt = S_MACC_1;
            else if (uop[UOP_MMUL]) state_nxt = S_MDR;
            else                    state_nxt = S_INIT;
          end
        end
        S_MDR:    state_nxt = last_mdr ? S_MMUL_1 : S_MDR;
        S_MSUB_1: state_nxt = S_DONE;
        S_MACC_1: state_nxt = S_DONE;
        S_MMUL_1: state_nxt = S_MMUL_2;
        S_MMUL_2: state_nxt = S_DONE;
        S_DONE:   state_nxt = S_INIT;
        default:  state_nxt = S_INIT;
      endcase
    end
  end

  // Entering INIT always clears; DONE itself never loads (it always exits to INIT).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_INIT;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_INIT) begin
        acc   <= '0;
        carry <= 1'b0;
      end else if (state != S_DONE) begin
        acc   <= n_acc;
        carry <= n_carry;
      end
      if (state_nxt == S_MDR && state == S_MDR) count <= count + COUNT_W'(1);
      else                                       count <= '0;
    end
  end

  assign fsm_init   = (state == S_INIT);
  assign fsm_mdr    = (state == S_MDR);
  assign fsm_msub_1 = (state == S_MSUB_1);
  assign fsm_macc_1 = (state == S_MACC_1);
  assign fsm_mmul_1 = (state == S_MMUL_1);
  assign fsm_mmul_2 = (state == S_MMUL_2);
  assign fsm_done   = (state == S_DONE);

  assign ready = active & (fsm_done | (fsm_init & uop_madd & uop_legal));

endmodule

// File: tb/tb_xc_malu_ctrl.sv
// Scoreboard bench for xc_malu_ctrl: driver predicts each completion from
// operation latencies, a negedge monitor checks every ready it sees.
module tb_xc_malu_ctrl;

  localparam int MDR = 32;
  localparam int CW  = 6;

  logic          clock = 1'b0;
  logic          resetn;
  logic          flush;
  logic          valid;
  logic          uop_madd, uop_msub, uop_macc, uop_mmul;
  logic [63:0]   n_acc;
  logic          n_carry;
  logic          fsm_init, fsm_mdr, fsm_msub_1, fsm_macc_1, fsm_mmul_1, fsm_mmul_2, fsm_done;
  logic [63:0]   acc;
  logic          carry;
  logic [CW-1:0] count;
  logic          ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [63:0] acc;
    logic        carry;
  } exp_t;
  exp_t sb[$];

  xc_malu_ctrl #(.MDR_STEPS(MDR), .COUNT_W(CW)) dut (
    .clock(clock), .resetn(resetn), .flush(flush), .valid(valid),
    .uop_madd(uop_madd), .uop_msub(uop_msub), .uop_macc(uop_macc), .uop_mmul(uop_mmul),
    .n_acc(n_acc), .n_carry(n_carry),
    .fsm_init(fsm_init), .fsm_mdr(fsm_mdr), .fsm_msub_1(fsm_msub_1), .fsm_macc_1(fsm_macc_1),
    .fsm_mmul_1(fsm_mmul_1), .fsm_mmul_2(fsm_mmul_2), .fsm_done(fsm_done),
    .acc(acc), .carry(carry), .count(count), .ready(ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: one-hot strobes every cycle, and every ready matched against the scoreboard.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      chk("onehot", 64'($countones({fsm_init, fsm_mdr, fsm_msub_1, fsm_macc_1,
                                    fsm_mmul_1, fsm_mmul_2, fsm_done})), 64'd1);
      if (ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 64'(ready), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ready_cycle", 64'(cyc), 64'(e.cyc));
          chk("done_acc", acc, e.acc);
          chk("done_carry", 64'(carry), 64'(e.carry));
        end
      end
    end
  end

  function automatic int lat(input int op);
    case (op)
      0:       return 1;
      1, 2:    return 3;
      default: return MDR + 4;
    endcase
  endfunction

  task automatic idle_inputs();
    valid = 1'b0; flush = 1'b0;
    uop_madd = 1'b0; uop_msub = 1'b0; uop_macc = 1'b0; uop_mmul = 1'b0;
  endtask

  // op: 0 madd, 1 msub, 2 macc, 3 mmul. ab_kind: 0 none, 1 flush, 2 valid drop, 3 async reset.
  task automatic issue(input int op, input int ab_at, input int ab_kind);
    int L;
    int t0;
    exp_t e;
    L  = lat(op);
    t0 = cyc;
    for (int i = 0; i < L; i++) begin
      valid = 1'b1; flush = 1'b0;
      uop_madd = (op == 0); uop_msub = (op == 1); uop_macc = (op == 2); uop_mmul = (op == 3);
      n_acc = {$urandom, $urandom};
      n_carry = 1'($urandom);
      if (op == 3) begin
        chk("mdr_strobe", 64'(fsm_mdr), 64'(i >= 1 && i <= MDR));
        chk("mdr_count", 64'(count), (i >= 1 && i <= MDR) ? 64'(i - 1) : 64'd0);
      end
      if (op != 0) chk("done_strobe", 64'(fsm_done), 64'(i == L - 1));
      if (i == ab_at) begin
        if (ab_kind == 3) begin
          #2 resetn = 1'b0;
          #1;
          chk("rst_init", 64'(fsm_init), 64'd1);
          chk("rst_mmul2", 64'(fsm_mmul_2), 64'd0);
          chk("rst_acc", acc, 64'd0);
          chk("rst_carry", 64'(carry), 64'd0);
          chk("rst_count", 64'(count), 64'd0);
          chk("rst_ready", 64'(ready), 64'd0);
          idle_inputs();
          @(posedge clock); #1;
          resetn = 1'b1;
        end else begin
          if (ab_kind == 1) flush = 1'b1;
          else              valid = 1'b0;
          #1;
          chk("abort_ready", 64'(ready), 64'd0);
          @(posedge clock); #1;
          chk("abort_init", 64'(fsm_init), 64'd1);
          chk("abort_acc", acc, 64'd0);
          chk("abort_carry", 64'(carry), 64'd0);
          chk("abort_count", 64'(count), 64'd0);
          idle_inputs();
        end
        return;
      end
      if (ab_kind == 0 && op == 0) begin
        e.cyc = t0; e.acc = 64'd0; e.carry = 1'b0;
        sb.push_back(e);
      end else if (ab_kind == 0 && i == L - 2) begin
        e.cyc = t0 + L - 1; e.acc = n_acc; e.carry = n_carry;
        sb.push_back(e);
      end
      @(posedge clock); #1;
    end
    idle_inputs();
    chk("post_init", 64'(fsm_init), 64'd1);
    chk("post_acc", acc, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();
    n_acc = '0; n_carry = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_init", 64'(fsm_init), 64'd1);
    chk("reset_others", 64'({fsm_mdr, fsm_msub_1, fsm_macc_1, fsm_mmul_1, fsm_mmul_2, fsm_done}), 64'd0);
    chk("reset_acc", acc, 64'd0);
    chk("reset_carry", 64'(carry), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    issue(0, -1, 0);
    issue(1, -1, 0);
    issue(2, -1, 0);
    issue(3, -1, 0);
    issue(3, 11, 1);           // flush while count==10
    issue(1, 2, 1);            // flush beats completion in DONE
    issue(2, 1, 2);            // valid drops in MACC_1 ...
    issue(0, -1, 0);           // ... and madd follows immediately
    issue(3, MDR + 2, 3);      // async reset in MMUL_2

    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      uop_madd = (k != 3); uop_msub = (k != 3); uop_macc = (k == 2); uop_mmul = 1'b0;
      n_acc = {$urandom, $urandom} | 64'd1;
      n_carry = 1'b1;
      #1;
      chk("illegal_ready", 64'(ready), 64'd0);
      @(posedge clock); #1;
      chk("illegal_init", 64'(fsm_init), 64'd1);
      chk("illegal_acc", acc, 64'd0);
      chk("illegal_carry", 64'(carry), 64'd0);
    end
    idle_inputs();

    for (int k = 0; k < 40; k++) begin
      issue(int'($urandom_range(0, 3)), -1, 0);
      repeat ($urandom_range(0, 2)) begin
        n_acc = {$urandom, $urandom};
        @(posedge clock); #1;
      end
    end

    repeat (3) @(posedge clock);
    #1;
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
